// File: rtl/bike_sparse_writer_pkg.sv
// -----------------------------------------------------------------------------
// bike_sparse_writer_pkg
// Shared BIKE geometry constants for the sparse-vector writer and its BRAM
// wrapper: vector length in bits, index width, number of 32-bit words in the
// vector and the matching word-address width, plus the default error weight.
// -----------------------------------------------------------------------------
package bike_sparse_writer_pkg;

    // Length of the sparse vector in bits.
    localparam int R_BITS    = 100;
    // Width of a bit index into the vector.
    localparam int LOGRBITS  = $clog2(R_BITS);
    // Number of 32-bit words holding the vector (last word partially used).
    localparam int DWORDS    = (R_BITS + 31) / 32;
    // Width of a 32-bit word address.
    localparam int LOGDWORDS = $clog2(DWORDS);
    // Default number of distinct set bits per run.
    localparam int T         = 5;

    // Single-bit mask inside a 32-bit word.
    function automatic logic [31:0] bit_mask(input logic [4:0] pos);
        return 32'h1 << pos;
    endfunction

endpackage

// File: rtl/bike_sparse_writer.sv
// -----------------------------------------------------------------------------
// bike_sparse_writer
// Clears an R_BITS-bit vector held in an external BRAM, then sets WEIGHT
// distinct bits in it from a stream of candidate indices. Out-of-range and
// duplicate indices are dropped with a one-cycle reject pulse.
//
// Ports
//   clk, resetn             system clock, asynchronous active-low reset
//   start                   pulse that launches one clear-and-fill run
//   busy, done              run in progress / single-cycle end-of-run pulse
//   idx_valid, idx_ready    index stream handshake
//   idx                     candidate bit position
//   reject                  pulse for an out-of-range or duplicate index
//   sampling                BRAM port select, mirrors busy
//   wen_samp, ren_samp      BRAM write / read enables
//   addr_samp               32-bit word address
//   din_samp                write data
//   dout_samp               read data, valid one cycle after ren_samp
//
// State      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for start, BRAM port released
// CLEAR      | writing zero to word clr_addr, one word per cycle
// WAIT_IDX   | idx_ready high, waiting for a candidate index
// READ       | reading the word that holds the accepted index
// MODIFY     | read data present: set the bit, or reject a duplicate
// DONE       | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module bike_sparse_writer
    import bike_sparse_writer_pkg::*;
#(
    parameter int WEIGHT = T
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 idx_valid,
    output logic                 idx_ready,
    input  logic [LOGRBITS-1:0]  idx,
    output logic                 reject,
    output logic                 sampling,
    output logic                 wen_samp,
    output logic                 ren_samp,
    output logic [LOGDWORDS-1:0] addr_samp,
    output logic [31:0]          din_samp,
    input  logic [31:0]          dout_samp
);

    localparam int CNT_W = $clog2(WEIGHT + 1);

    localparam logic [CNT_W-1:0]     WEIGHT_C  = CNT_W'(WEIGHT);
    localparam logic [LOGRBITS-1:0]  R_LIMIT   = LOGRBITS'(R_BITS);
    localparam logic [LOGDWORDS-1:0] LAST_WORD = LOGDWORDS'(DWORDS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WAIT_IDX = 3'd2,
        READ     = 3'd3,
        MODIFY   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [LOGDWORDS-1:0] clr_addr;
    logic [LOGRBITS-1:0]  idx_q;

    logic [CNT_W-1:0]     cnt_next;
    logic [LOGDWORDS-1:0] word_sel;
    logic [31:0]          set_mask;
    logic                 bit_set;

    assign cnt_next = cnt + 1'b1;
    assign word_sel = LOGDWORDS'(idx_q >> 5);
    assign set_mask = bit_mask(idx_q[4:0]);
    // dout_samp is only meaningful in MODIFY, one cycle after the READ strobe.
    assign bit_set  = dout_samp[idx_q[4:0]];

    // -------------------------------------------------------------------------
    // Control FSM; busy, done and reject are registered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_addr <= '0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            reject   <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_WORD) begin
                        state    <= WAIT_IDX;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                WAIT_IDX: begin
                    if (idx_valid) begin
                        if (idx >= R_LIMIT) begin
                            // Out of range: drop it and keep listening.
                            reject <= 1'b1;
                        end else begin
                            idx_q <= idx;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state <= MODIFY;
                end
                MODIFY: begin
                    if (bit_set) begin
                        reject <= 1'b1;
                        state  <= WAIT_IDX;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == WEIGHT_C) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_IDX;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign idx_ready = (state == WAIT_IDX);
    assign sampling  = busy;

    // -------------------------------------------------------------------------
    // BRAM port. Decoded from state so the MODIFY write can use read data in
    // the same cycle it arrives, keeping accept-to-write at three cycles.
    // -------------------------------------------------------------------------
    always_comb begin
        wen_samp  = 1'b0;
        ren_samp  = 1'b0;
        addr_samp = '0;
        din_samp  = '0;
        case (state)
            CLEAR: begin
                wen_samp  = 1'b1;
                addr_samp = clr_addr;
            end
            READ: begin
                ren_samp  = 1'b1;
                addr_samp = word_sel;
            end
            MODIFY: begin
                addr_samp = word_sel;
                if (!bit_set) begin
                    wen_samp = 1'b1;
                    din_samp = dout_samp | set_mask;
                end
            end
            default: begin
                wen_samp  = 1'b0;
                ren_samp  = 1'b0;
                addr_samp = '0;
                din_samp  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bike_sparse_writer.sv
module tb_bike_sparse_writer;
    import bike_sparse_writer_pkg::*;

    localparam int W = 3;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done;
    logic                 idx_valid = 1'b0;
    logic                 idx_ready;
    logic [LOGRBITS-1:0]  idx = '0;
    logic                 reject, sampling;
    logic                 wen_samp, ren_samp;
    logic [LOGDWORDS-1:0] addr_samp;
    logic [31:0]          din_samp;
    logic [31:0]          dout_samp = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // BRAM model and bus monitors
    logic [31:0]          mem [DWORDS];
    logic [LOGDWORDS-1:0] wr_addr_q [$];
    logic [31:0]          wr_data_q [$];
    int rej_cnt = 0, done_cnt = 0, acc_cnt = 0, overlap_cnt = 0;

    bike_sparse_writer #(.WEIGHT(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
        .reject(reject), .sampling(sampling), .wen_samp(wen_samp),
        .ren_samp(ren_samp), .addr_samp(addr_samp), .din_samp(din_samp),
        .dout_samp(dout_samp)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DWORDS; i++) mem[i] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren_samp) dout_samp <= mem[addr_samp];
        if (wen_samp) begin
            mem[addr_samp] <= din_samp;
            wr_addr_q.push_back(addr_samp);
            wr_data_q.push_back(din_samp);
        end
    end

    always @(negedge clk) begin
        if (reject) rej_cnt <= rej_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (wen_samp || ren_samp) acc_cnt <= acc_cnt + 1;
        if (wen_samp && ren_samp) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!idx_ready && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(idx_ready), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic send_idx(input logic [LOGRBITS-1:0] v);
        int n = 0;
        idx = v;
        idx_valid = 1'b1;
        while (!idx_ready && n < 60) begin
            step();
            n++;
        end
        if (!idx_ready) chk("accept_timeout", 32'd0, 32'd1);
        step();
        idx_valid = 1'b0;
    endtask

    task automatic start_run();
        wr_addr_q.delete();
        wr_data_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(DWORDS));
        for (int i = 0; i < DWORDS && i < wr_addr_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_data"}, wr_data_q[i], 32'h0);
        end
    endtask

    int r0, d0, a0, k;
    int acc_cyc [3];
    logic [LOGRBITS-1:0] stream [3];

    initial begin
        // reset state
        #12;
        chk("rst_ctrl", 32'({busy, done, idx_ready, reject, sampling, wen_samp, ren_samp}), 32'd0);
        chk("rst_addr_din", 32'(addr_samp) | din_samp, 32'd0);
        resetn = 1'b1;
        step();
        chk("idle_ctrl", 32'({busy, idx_ready, wen_samp, ren_samp}), 32'd0);

        // Run 1: clear, restart attempt during CLEAR, indices 5,37,5,40
        start_run();
        chk("busy_after_start", 32'({busy, sampling}), 32'h3);
        chk("clear_first", 32'({wen_samp, addr_samp}), 32'({1'b1, 2'd0}));
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ready("clr_ready");
        check_clear("clear1");
        chk("wait_port_zero", 32'({wen_samp, ren_samp, addr_samp}) | din_samp, 32'd0);
        r0 = rej_cnt;
        d0 = done_cnt;
        send_idx(7'd5);
        chk("read_strobe", 32'({ren_samp, wen_samp, addr_samp}), 32'({1'b1, 1'b0, 2'd0}));
        send_idx(7'd37);
        send_idx(7'd5);
        send_idx(7'd40);
        wait_idle("run1_idle");
        chk("run1_nwr", 32'(wr_addr_q.size()), 32'(DWORDS + 3));
        if (wr_addr_q.size() == DWORDS + 3) begin
            chk("run1_w0", {30'd0, wr_addr_q[DWORDS]}, 32'd0);
            chk("run1_d0", wr_data_q[DWORDS], 32'h20);
            chk("run1_w1", {30'd0, wr_addr_q[DWORDS+1]}, 32'd1);
            chk("run1_d1", wr_data_q[DWORDS+1], 32'h20);
            chk("run1_w2", {30'd0, wr_addr_q[DWORDS+2]}, 32'd1);
            chk("run1_d2", wr_data_q[DWORDS+2], 32'h120);
        end
        chk("run1_rej", 32'(rej_cnt - r0), 32'd1);
        chk("run1_done", 32'(done_cnt - d0), 32'd1);
        chk("run1_mem1", mem[1], 32'h120);
        chk("run1_mem3", mem[3], 32'h0);
        chk("idle_outputs", 32'({sampling, idx_ready, wen_samp, ren_samp}), 32'd0);

        // Run 2: range boundary R_BITS / R_BITS-1
        start_run();
        wait_ready("run2_ready");
        r0 = rej_cnt;
        a0 = acc_cnt;
        send_idx(7'(R_BITS));
        chk("range_rej_pulse", 32'(reject), 32'd1);
        chk("range_still_ready", 32'(idx_ready), 32'd1);
        step();
        step();
        chk("range_no_access", 32'(acc_cnt - a0), 32'd0);
        send_idx(7'(R_BITS - 1));
        step();
        step();
        chk("last_bit_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'((R_BITS - 1) >> 5));
        chk("last_bit_data", wr_data_q[wr_data_q.size()-1], 32'h8);
        send_idx(7'd127);
        send_idx(7'd0);
        send_idx(7'd64);
        wait_idle("run2_idle");
        chk("run2_rej", 32'(rej_cnt - r0), 32'd2);
        chk("run2_mem", mem[0] ^ mem[2] ^ (mem[3] << 4), 32'h0000_0080);

        // Run 3: idx_valid held high, accepts every 3 cycles
        start_run();
        wait_ready("run3_ready");
        stream[0] = 7'd10;
        stream[1] = 7'd50;
        stream[2] = 7'd90;
        k = 0;
        idx = stream[0];
        idx_valid = 1'b1;
        for (int n = 0; n < 60 && k < 3; n++) begin
            if (idx_ready) begin
                acc_cyc[k] = cyc;
                k++;
                step();
                if (k < 3) idx = stream[k];
                else idx_valid = 1'b0;
            end else begin
                step();
            end
        end
        idx_valid = 1'b0;
        chk("stream_accepts", 32'(k), 32'd3);
        chk("stream_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("stream_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        wait_idle("run3_idle");
        chk("stream_nwr", 32'(wr_addr_q.size()), 32'(DWORDS + 3));
        chk("stream_m0", mem[0], 32'h0000_0400);
        chk("stream_m1", mem[1], 32'h0004_0000);
        chk("stream_m2", mem[2], 32'h0400_0000);

        // Run 4: reset asserted during MODIFY, then a clean rerun
        start_run();
        wait_ready("run4_ready");
        send_idx(7'd7);
        step();
        chk("in_modify", 32'({wen_samp, ren_samp}), 32'h2);
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({busy, done, idx_ready, reject, sampling, wen_samp, ren_samp}), 32'd0);
        chk("rst_mid_bus", 32'(addr_samp) | din_samp, 32'd0);
        #2 resetn = 1'b1;
        step();
        start_run();
        wait_ready("run5_ready");
        check_clear("clear5");
        d0 = done_cnt;
        send_idx(7'd7);
        send_idx(7'd8);
        send_idx(7'd9);
        wait_idle("run5_idle");
        chk("run5_done", 32'(done_cnt - d0), 32'd1);
        chk("run5_m0", mem[0], 32'h0000_0380);
        chk("run5_m1", mem[1] | mem[2] | mem[3], 32'h0);

        chk("no_wen_ren_overlap", 32'(overlap_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bike_sparse_writer.md
BIKE_SPARSE_WRITER -- requirements
Module: BIKE_sparse_writer

Interface
REQ-001 SHALL have parameter WEIGHT, default T (from BIKE_PACKAGE), giving the number of distinct set bits to write.
REQ-002 SHALL have clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-003 SHALL have resetn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have start, input, 1 bit: pulse that begins one clear-and-fill run; ignored when busy=1.
REQ-005 SHALL have busy / done, output, 1 bit each: busy is high from the cycle after an accepted start until done; done is a single-cycle pulse at the end of the run.
REQ-006 SHALL have idx_valid / idx_ready, input / output, 1 bit each: the index stream handshake.
REQ-007 SHALL have idx, input, LOGRBITS bits: candidate bit position in the R_BITS-bit vector.
REQ-008 SHALL have reject, output, 1 bit: one-cycle pulse when an index is out of range or a duplicate.
REQ-009 SHALL have sampling, output, 1 bit: memory-port select to the downstream generic BRAM wrapper; equal to busy.
REQ-010 SHALL have wen_samp / ren_samp, output, 1 bit each: write and read enables on the 32-bit sampling port.
REQ-011 SHALL have addr_samp, output, LOGDWORDS bits: 32-bit word address.
REQ-012 SHALL have din_samp, output, 32 bits: write data.
REQ-013 SHALL have dout_samp, input, 32 bits: read data, valid exactly one cycle after ren_samp.

Function
REQ-014 SHALL use FSM states IDLE, CLEAR, WAIT_IDX, READ, MODIFY, DONE.
REQ-015 SHALL go IDLE -> CLEAR on start=1, and SHALL clear the accepted-bit counter at that transition.
REQ-016 In CLEAR, SHALL write din_samp=0, wen_samp=1 to addresses 0..DWORDS-1, one per cycle, then go to WAIT_IDX.
REQ-017 In WAIT_IDX, SHALL drive idx_ready=1; idx_ready SHALL be 0 in every other state.
REQ-018 On idx_valid&&idx_ready with idx>=R_BITS, SHALL pulse reject the next cycle and remain in WAIT_IDX.
REQ-019 On idx_valid&&idx_ready with idx<R_BITS, SHALL register idx and go to READ.
REQ-020 In READ, SHALL drive ren_samp=1 and addr_samp=idx[LOGRBITS-1:5], then go to MODIFY.
REQ-021 In MODIFY, if dout_samp[idx[4:0]]=1, SHALL pulse reject with no write.
REQ-022 In MODIFY, if dout_samp[idx[4:0]]=0, SHALL drive wen_samp=1, the same addr_samp, and din_samp = dout_samp | (1<<idx[4:0]), and SHALL increment the counter.
REQ-023 From MODIFY, SHALL go to DONE if the counter equals WEIGHT after the update, else to WAIT_IDX.
REQ-024 Each index SHALL take 3 cycles from accept to write (accept, READ, MODIFY); the next accept SHALL be possible in the following cycle.
REQ-025 DONE SHALL last one cycle: done=1, busy=0 and sampling=0 from the next cycle, then IDLE.
REQ-026 wen_samp and ren_samp SHALL never be high in the same cycle.
REQ-027 addr_samp, din_samp, wen_samp and ren_samp SHALL all be 0 in IDLE, WAIT_IDX and DONE.
REQ-028 The counter SHALL be $clog2(WEIGHT+1) bits wide and SHALL never exceed WEIGHT.
REQ-029 A start asserted while busy=1 SHALL have no effect.

Reset
REQ-030 resetn=0 SHALL force IDLE, counter=0, and every output to 0, asynchronously.
REQ-031 A reset mid-run SHALL leave memory content undefined; the next start fully re-clears the vector.

Structure
REQ-032 R_BITS, LOGRBITS, DWORDS, LOGDWORDS and T SHALL come from BIKE_PACKAGE; the FSM state enum SHALL be local.
REQ-033 The block SHALL be a single module with no sub-modules; it is instantiated beside BIKE_generic_bram and drives that wrapper's sampling port.

Verification
REQ-034 start, then wait -> exactly DWORDS zero writes at addresses 0..DWORDS-1, then idx_ready=1.
REQ-035 WEIGHT=3, indices 5, 37, 5, 40 -> words 0 and 1 written as 0x20 and 0x20 then 0x120; reject pulses on the second 5; done after 40.
REQ-036 idx=R_BITS, then idx=R_BITS-1 -> reject, no memory access; then a write to word (R_BITS-1)>>5.
REQ-037 idx_valid held high continuously -> an accept every 3 cycles, no missed or double-accepted index.
REQ-038 resetn low during MODIFY -> all outputs 0 immediately; a new start reruns CLEAR and produces a correct result.
REQ-039 start pulsed during CLEAR -> CLEAR does not restart, and a single done is produced.
